// File: rtl/mailbox_pkg.sv
// Shared constants and types for the inter-CPU mailbox: register offsets,
// FSM state encoding and STATUS word bit positions.
package mailbox_pkg;

  localparam logic [7:0] MB_INBOX     = 8'h00;
  localparam logic [7:0] MB_STATUS    = 8'h04;
  localparam logic [7:0] MB_SEND_BASE = 8'h40;

  typedef enum logic [1:0] {
    MB_IDLE,
    MB_EXEC,
    MB_ACK
  } mb_state_t;

  // STATUS word layout: {count at bit 8 upward, full, empty}
  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/mailbox_if.sv
// Request/response bundle between the per-CPU request mux (master) and the
// mailbox storage stage (slave).
interface mailbox_if #(
  parameter int W_WIDTH_SYS = 32,
  parameter int N_NUMB_CPU  = 4
);

  logic [N_NUMB_CPU-1:0]  req_i;
  logic [W_WIDTH_SYS-1:0] addr_i;
  logic [W_WIDTH_SYS-1:0] data_i;
  logic                   write_i;
  logic [31:0]            numb_cpu_i;
  logic [W_WIDTH_SYS-1:0] rdata_o;
  logic                   err_o;
  logic [N_NUMB_CPU-1:0]  ack_o;
  logic [N_NUMB_CPU-1:0]  irq_o;

  modport master (
    output req_i, addr_i, data_i, write_i, numb_cpu_i,
    input  rdata_o, err_o, ack_o, irq_o
  );

  modport slave (
    input  req_i, addr_i, data_i, write_i, numb_cpu_i,
    output rdata_o, err_o, ack_o, irq_o
  );

endinterface

// File: rtl/mbox_fifo.sv
// Single inbox: D-deep word FIFO with occupancy count. Pointers wrap modulo D,
// so D must be a power of two.
module mbox_fifo #(
  parameter int W = 32,
  parameter int D = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [W-1:0]       i_data,
  input  logic               i_pop,
  output logic [W-1:0]       o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [$clog2(D):0] o_count
);

  localparam int AW = $clog2(D);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(D);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; resetting the pointers is enough to discard contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mailbox_core.sv
// Mailbox storage stage: accepts one arbitrated request at a time, decodes it
// against the inbox/status/send map and answers with a 4-phase per-CPU ack.
module mailbox_core
  import mailbox_pkg::*;
#(
  parameter int W_WIDTH_SYS = 32,
  parameter int N_NUMB_CPU  = 4,
  parameter int D_DEPTH     = 8
) (
  input  logic     clk,
  input  logic     rst,
  mailbox_if.slave bus
);

  localparam int W    = W_WIDTH_SYS;
  localparam int N    = N_NUMB_CPU;
  localparam int CW   = $clog2(N);
  localparam int CNTW = $clog2(D_DEPTH) + 1;

  mb_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cpu;
  logic [W-1:0]  r_addr;
  logic [W-1:0]  r_data;
  logic          r_write;
  logic [W-1:0]  r_rdata;
  logic          r_err;
  logic [N-1:0]  r_ack;
  logic [N-1:0]  r_irq;

  logic [W-1:0]    w_fifo_data [N];
  logic [CNTW-1:0] w_count [N];
  logic [N-1:0]    w_full, w_empty, w_push, w_pop;

  logic          w_req_sel, w_req_cur;
  logic [CW-1:0] w_cpu_idx;
  logic [N-1:0]  w_cpu_oh, w_send_oh;
  logic          w_cur_empty, w_cur_full, w_send_hit, w_send_full;
  logic [CNTW-1:0] w_cur_count;
  logic [W-1:0]  w_cur_data, w_status, w_rdata;
  logic          w_err;

  for (genvar g = 0; g < N; g++) begin : g_inbox
    mbox_fifo #(.W(W), .D(D_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[g]),
      .i_data  (r_data),
      .i_pop   (w_pop[g]),
      .o_data  (w_fifo_data[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_count (w_count[g])
    );
  end

  // Out-of-range CPU indices simply never match, so they are ignored.
  always_comb begin
    w_req_sel = 1'b0;
    w_cpu_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.numb_cpu_i == 32'(k)) begin
        w_req_sel = bus.req_i[k];
        w_cpu_idx = CW'(k);
      end
    end
  end

  always_comb begin
    w_cpu_oh    = '0;
    w_req_cur   = 1'b0;
    w_cur_empty = 1'b1;
    w_cur_full  = 1'b0;
    w_cur_count = '0;
    w_cur_data  = '0;
    for (int k = 0; k < N; k++) begin
      if (r_cpu == CW'(k)) begin
        w_cpu_oh[k] = 1'b1;
        w_req_cur   = bus.req_i[k];
        w_cur_empty = w_empty[k];
        w_cur_full  = w_full[k];
        w_cur_count = w_count[k];
        w_cur_data  = w_fifo_data[k];
      end
    end
  end

  // Anything not explicitly legal falls through with err set and no FIFO effect.
  always_comb begin
    w_err       = 1'b1;
    w_rdata     = '0;
    w_push      = '0;
    w_pop       = '0;
    w_status    = '0;
    w_send_hit  = 1'b0;
    w_send_full = 1'b1;
    w_send_oh   = '0;
    w_status[ST_COUNT_LSB +: CNTW] = w_cur_count;
    w_status[ST_FULL_BIT]          = w_cur_full;
    w_status[ST_EMPTY_BIT]         = w_cur_empty;
    for (int k = 0; k < N; k++) begin
      if (r_addr[5:2] == 4'(k)) begin
        w_send_hit   = 1'b1;
        w_send_full  = w_full[k];
        w_send_oh[k] = 1'b1;
      end
    end
    if (r_addr[W-1:8] == '0) begin
      if (r_addr[7:0] == MB_INBOX) begin
        if (!r_write && !w_cur_empty) begin
          w_err   = 1'b0;
          w_rdata = w_cur_data;
          w_pop   = w_cpu_oh;
        end
      end else if (r_addr[7:0] == MB_STATUS) begin
        if (!r_write) begin
          w_err   = 1'b0;
          w_rdata = w_status;
        end
      end else if (r_addr[7:6] == MB_SEND_BASE[7:6] && r_addr[1:0] == 2'b00) begin
        if (r_write && w_send_hit && !w_send_full) begin
          w_err  = 1'b0;
          w_push = w_send_oh;
        end
      end
    end
    if (r_state != MB_EXEC) begin
      w_push = '0;
      w_pop  = '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MB_IDLE: if (w_req_sel) w_state_nxt = MB_EXEC;
      MB_EXEC: w_state_nxt = MB_ACK;
      MB_ACK:  if (!w_req_cur) w_state_nxt = MB_IDLE;
      default: w_state_nxt = MB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MB_IDLE;
      r_cpu   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_write <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_ack   <= '0;
      r_irq   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= ~w_empty;
      if (r_state == MB_IDLE && w_req_sel) begin
        r_cpu   <= w_cpu_idx;
        r_addr  <= bus.addr_i;
        r_data  <= bus.data_i;
        r_write <= bus.write_i;
      end
      if (r_state == MB_EXEC) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
        r_ack   <= w_cpu_oh;
      end else if (r_state == MB_ACK && !w_req_cur) begin
        r_ack <= '0;
      end
    end
  end

  assign bus.rdata_o = r_rdata;
  assign bus.err_o   = r_err;
  assign bus.ack_o   = r_ack;
  assign bus.irq_o   = r_irq;

endmodule

// File: tb/tb_mailbox_core.sv
// Directed plus randomized checks of mailbox_core against a queue-based model
// of the inboxes and the address map.
module tb_mailbox_core;

  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCompared   = 0;
  int   nMismatched = 0;

  logic [31:0] mbq [N][$];

  mailbox_if #(.W_WIDTH_SYS(W), .N_NUMB_CPU(N)) bus ();

  mailbox_core #(.W_WIDTH_SYS(W), .N_NUMB_CPU(N), .D_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assert property (@(posedge clk) $onehot0(bus.ack_o))
    else begin
      nMismatched++;
      $error("[TB] FAIL ack_onehot0: observed ack_o=%b, required at most one bit set", bus.ack_o);
    end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp)
      else begin
        nMismatched++;
        $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  // Reference model of one access: the address map and inbox rules as plain arithmetic.
  task automatic modelAccess(input int cpu, input logic [31:0] addr, input logic [31:0] data,
                             input logic wr, output logic [31:0] expRd, output logic expEr);
    int off, k;
    expRd = 32'h0;
    expEr = 1'b1;
    off   = int'(addr & 32'hFF);
    if ((addr >> 8) != 0) return;
    if (off == 0) begin
      if (!wr && mbq[cpu].size() > 0) begin
        expEr = 1'b0;
        expRd = mbq[cpu].pop_front();
      end
    end else if (off == 4) begin
      if (!wr) begin
        expEr = 1'b0;
        expRd = (mbq[cpu].size() * 256) + ((mbq[cpu].size() == D) ? 2 : 0) +
                ((mbq[cpu].size() == 0) ? 1 : 0);
      end
    end else if (off >= 'h40 && off < 'h80 && (off % 4) == 0) begin
      k = (off - 'h40) / 4;
      if (k < N && wr && mbq[k].size() < D) begin
        expEr = 1'b0;
        mbq[k].push_back(data);
      end
    end
  endtask

  function automatic logic [N-1:0] modelIrq();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = (mbq[k].size() != 0);
    return v;
  endfunction

  task automatic applyStimulus(input int cpu, input logic [31:0] addr, input logic [31:0] data,
                               input logic wr, input int holdCycles,
                               output logic [31:0] rd, output logic er);
    logic [31:0] expRd;
    logic        expEr;
    logic [N-1:0] expAck;
    int edges;
    modelAccess(cpu, addr, data, wr, expRd, expEr);
    expAck         = N'(1) << cpu;
    bus.numb_cpu_i = 32'(cpu);
    bus.addr_i     = addr;
    bus.data_i     = data;
    bus.write_i    = wr;
    bus.req_i      = expAck;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (bus.ack_o !== expAck && edges < 20);
    checkOutput("ack_latency", 32'(edges), 32'd2);
    rd = bus.rdata_o;
    er = bus.err_o;
    checkOutput("rdata", rd, expRd);
    checkOutput("err", 32'(er), 32'(expEr));
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_ack", 32'(bus.ack_o), 32'(expAck));
      checkOutput("hold_rdata", bus.rdata_o, expRd);
      checkOutput("hold_err", 32'(bus.err_o), 32'(expEr));
    end
    bus.req_i = '0;
    @(posedge clk); #1;
    checkOutput("ack_fall", 32'(bus.ack_o), 32'h0);
    checkOutput("irq", 32'(bus.irq_o), 32'(modelIrq()));
  endtask

  initial begin
    logic [31:0] rd, word;
    logic er;
    logic [31:0] saved [D];
    int edges, cpu, sel;
    logic [31:0] addr;
    logic wr;

    bus.req_i = '0; bus.addr_i = '0; bus.data_i = '0; bus.write_i = 1'b0; bus.numb_cpu_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rdata", bus.rdata_o, 32'h0);
    checkOutput("rst_err", 32'(bus.err_o), 32'h0);
    checkOutput("rst_ack", 32'(bus.ack_o), 32'h0);
    checkOutput("rst_irq", 32'(bus.irq_o), 32'h0);
    rst = 1'b0;

    // 1: basic post and pop
    applyStimulus(0, 32'h44, 32'hDEAD_BEEF, 1'b1, 0, rd, er);
    checkOutput("t1_irq1_set", 32'(bus.irq_o[1]), 32'h1);
    applyStimulus(1, 32'h00, 32'h0, 1'b0, 0, rd, er);
    checkOutput("t1_pop_data", rd, 32'hDEAD_BEEF);
    checkOutput("t1_pop_err", 32'(er), 32'h0);
    checkOutput("t1_irq1_clr", 32'(bus.irq_o[1]), 32'h0);

    // 2: fill inbox 2 past full, status, drain in order
    for (int i = 0; i < 9; i++) begin
      word = $urandom;
      if (i < D) saved[i] = word;
      applyStimulus(0, 32'h48, word, 1'b1, 0, rd, er);
      checkOutput("t2_push_err", 32'(er), (i == 8) ? 32'h1 : 32'h0);
    end
    applyStimulus(2, 32'h04, 32'h0, 1'b0, 0, rd, er);
    checkOutput("t2_status_full", rd, 32'h0000_0802);
    for (int i = 0; i < D; i++) begin
      applyStimulus(2, 32'h00, 32'h0, 1'b0, 0, rd, er);
      checkOutput("t2_pop_order", rd, saved[i]);
    end

    // 3: error map
    applyStimulus(3, 32'h00, 32'h0, 1'b0, 0, rd, er);
    checkOutput("t3_empty_pop_err", 32'(er), 32'h1);
    checkOutput("t3_empty_pop_rdata", rd, 32'h0);
    applyStimulus(1, 32'h00, 32'h1234, 1'b1, 0, rd, er);
    checkOutput("t3_wr_inbox_err", 32'(er), 32'h1);
    applyStimulus(1, 32'h4C, 32'h5555, 1'b1, 0, rd, er);
    checkOutput("t3_send3_ok", 32'(er), 32'h0);
    applyStimulus(1, 32'h50, 32'h6666, 1'b1, 0, rd, er);
    checkOutput("t3_send4_err", 32'(er), 32'h1);
    applyStimulus(1, 32'h45, 32'h7777, 1'b1, 0, rd, er);
    checkOutput("t3_misalign_err", 32'(er), 32'h1);
    applyStimulus(1, 32'h100, 32'h8888, 1'b1, 0, rd, er);
    checkOutput("t3_high_addr_err", 32'(er), 32'h1);

    // Out-of-range CPU index must be ignored
    bus.numb_cpu_i = 32'd7;
    bus.req_i      = '1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("bad_cpu_no_ack", 32'(bus.ack_o), 32'h0);
    bus.req_i = '0;
    @(posedge clk); #1;

    // 4: long hold, then CPU3 is served right after the drop
    applyStimulus(1, 32'h04, 32'h0, 1'b0, 10, rd, er);
    applyStimulus(3, 32'h00, 32'h0, 1'b0, 0, rd, er);
    checkOutput("t4_cpu3_pop", rd, 32'h5555);

    // 5: reset while in ACK with three words queued
    for (int i = 0; i < 3; i++) applyStimulus(2, 32'h40, $urandom, 1'b1, 0, rd, er);
    bus.numb_cpu_i = 32'd1;
    bus.addr_i     = 32'h04;
    bus.write_i    = 1'b0;
    bus.req_i      = 4'b0010;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (bus.ack_o !== 4'b0010 && edges < 20);
    checkOutput("t5_ack_before_rst", 32'(bus.ack_o), 32'h2);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("t5_rst_ack", 32'(bus.ack_o), 32'h0);
    checkOutput("t5_rst_irq", 32'(bus.irq_o), 32'h0);
    rst = 1'b0;
    bus.req_i = '0;
    for (int k = 0; k < N; k++) mbq[k].delete();
    applyStimulus(0, 32'h04, 32'h0, 1'b0, 0, rd, er);
    checkOutput("t5_status_empty", rd, 32'h1);

    // 6: pointer wrap over three fill/drain rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < D; i++) applyStimulus($urandom_range(0, N-1), 32'h4C, $urandom, 1'b1, 0, rd, er);
      for (int i = 0; i < D; i++) applyStimulus(3, 32'h00, 32'h0, 1'b0, 0, rd, er);
    end

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      cpu = $urandom_range(0, N-1);
      sel = $urandom_range(0, 9);
      if (sel <= 2)      addr = 32'h00;
      else if (sel == 3) addr = 32'h04;
      else if (sel <= 7) addr = 32'h40 + 4 * $urandom_range(0, N);
      else if (sel == 8) addr = 32'h40 + $urandom_range(0, 63);
      else               addr = $urandom;
      if (sel >= 4 && sel <= 7) wr = ($urandom_range(0, 5) != 0);
      else                      wr = ($urandom_range(0, 4) == 0);
      applyStimulus(cpu, addr, $urandom, wr, $urandom_range(0, 2), rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
